// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the fetch stage
// and the memory stage. Data accesses win by default; a waiting fetch is
// forced through after STARVE_MAX consecutive data grants. A branch flush
// cancels a pending or in-flight fetch without producing if_ready.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req,
   input  logic [63:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_rdata,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [63:0] d_addr,
   input  logic [63:0] d_wdata,
   output logic        d_ready,
   output logic [63:0] d_rdata,
   input  logic        flush,
   output logic        m_req,
   output logic        m_we,
   output logic [63:0] m_addr,
   output logic [63:0] m_wdata,
   input  logic        m_ack,
   input  logic [63:0] m_rdata,
   output logic        stall_if,
   output logic        stall_mem
);

   localparam int unsigned CNT_W = (STARVE_MAX < 32'd3) ? 32'd2 : $clog2(STARVE_MAX + 32'd1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DGRANT = 2'd1,
      ST_FGRANT = 2'd2,
      ST_FDROP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              m_we_q, m_we_d;
   logic [63:0]       m_addr_q, m_addr_d;
   logic [63:0]       m_wdata_q, m_wdata_d;
   logic              if_ready_q, if_ready_d;
   logic              d_ready_q, d_ready_d;
   logic [31:0]       if_rdata_q, if_rdata_d;
   logic [63:0]       d_rdata_q, d_rdata_d;

   logic              d_any_s;
   logic              pick_fetch_s;
   logic              grant_d_s;
   logic              grant_f_s;

   // Arbitration decision taken in IDLE: data first unless the fetch is starved.
   always_comb begin
      d_any_s      = d_read | d_write;
      pick_fetch_s = if_req & (~d_any_s | (starve_q == STARVE_LIM));
      grant_f_s    = (state_q == ST_IDLE) & pick_fetch_s & ~flush;
      grant_d_s    = (state_q == ST_IDLE) & d_any_s & ~pick_fetch_s;
   end

   // State register and all datapath registers; reset abandons any access.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         starve_q   <= {CNT_W{1'b0}};
         m_we_q     <= 1'b0;
         m_addr_q   <= 64'd0;
         m_wdata_q  <= 64'd0;
         if_ready_q <= 1'b0;
         d_ready_q  <= 1'b0;
         if_rdata_q <= 32'd0;
         d_rdata_q  <= 64'd0;
      end else begin
         state_q    <= state_d;
         starve_q   <= starve_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         if_ready_q <= if_ready_d;
         d_ready_q  <= d_ready_d;
         if_rdata_q <= if_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   // Next-state logic; a flush turns an unfinished fetch into a drop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_d_s) begin
               state_d = ST_DGRANT;
            end else if (grant_f_s) begin
               state_d = ST_FGRANT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DGRANT: begin
            if (m_ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DGRANT;
            end
         end
         ST_FGRANT: begin
            if (m_ack) begin
               state_d = ST_IDLE;
            end else if (flush) begin
               state_d = ST_FDROP;
            end else begin
               state_d = ST_FGRANT;
            end
         end
         ST_FDROP: begin
            if (m_ack) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_FDROP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Datapath next values: capture request at grant, capture response at ack.
   always_comb begin
      starve_d   = starve_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      d_ready_d  = (state_q == ST_DGRANT) & m_ack;
      if_ready_d = (state_q == ST_FGRANT) & m_ack & ~flush;

      if (grant_d_s) begin
         m_addr_d  = d_addr;
         m_wdata_d = d_wdata;
         m_we_d    = d_write;
      end else if (grant_f_s) begin
         m_addr_d  = if_addr;
         m_we_d    = 1'b0;
      end else begin
         m_addr_d  = m_addr_q;
      end

      if (grant_f_s) begin
         starve_d = {CNT_W{1'b0}};
      end else if ((state_q == ST_IDLE) & ~if_req) begin
         starve_d = {CNT_W{1'b0}};
      end else if (grant_d_s & if_req & (starve_q != STARVE_LIM)) begin
         starve_d = starve_q + CNT_ONE;
      end else begin
         starve_d = starve_q;
      end

      if (d_ready_d & ~m_we_q) begin
         d_rdata_d = m_rdata;
      end else begin
         d_rdata_d = d_rdata_q;
      end

      if (if_ready_d) begin
         if_rdata_d = m_addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
      end else begin
         if_rdata_d = if_rdata_q;
      end
   end

   // Output decode: memory request follows the grant states; stalls are combinational.
   always_comb begin
      m_req     = (state_q != ST_IDLE);
      m_we      = m_we_q;
      m_addr    = m_addr_q;
      m_wdata   = m_wdata_q;
      if_ready  = if_ready_q;
      d_ready   = d_ready_q;
      if_rdata  = if_rdata_q;
      d_rdata   = d_rdata_q;
      stall_if  = if_req & ~if_ready_q;
      stall_mem = (d_read | d_write) & ~d_ready_q;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios followed by randomized
// traffic against a queue-based memory model; a monitor pops expected read
// data whenever a ready pulse appears.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [63:0] if_addr = 64'd0;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_read = 1'b0;
   logic        d_write = 1'b0;
   logic [63:0] d_addr = 64'd0;
   logic [63:0] d_wdata = 64'd0;
   logic        d_ready;
   logic [63:0] d_rdata;
   logic        flush = 1'b0;
   logic        m_req;
   logic        m_we;
   logic [63:0] m_addr;
   logic [63:0] m_wdata;
   logic        m_ack = 1'b0;
   logic [63:0] m_rdata = 64'd0;
   logic        stall_if;
   logic        stall_mem;

   int vecs = 0;
   int errs = 0;
   logic all_done = 1'b0;
   logic d_done = 1'b0;
   logic f_done = 1'b0;

   logic [63:0] d_exp[$];
   logic [31:0] f_exp[$];
   logic [63:0] mem[logic [63:0]];
   logic [63:0] ref_mem[logic [63:0]];
   logic [63:0] last_rd = 64'd0;

   mem_port_arbiter #(.STARVE_MAX(3)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata), .flush(flush),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   always #5 clock = ~clock;

   function automatic logic [63:0] init_val(input logic [63:0] a);
      return {a[31:0] ^ 32'h5A5A_0F0F, ~a[31:0] + 32'h1357_9BDF};
   endfunction

   function automatic logic [63:0] mem_get(input logic [63:0] k);
      if (mem.exists(k)) return mem[k];
      return init_val(k);
   endfunction

   function automatic logic [63:0] ref_get(input logic [63:0] k);
      if (ref_mem.exists(k)) return ref_mem[k];
      return init_val(k);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      fork
         // Monitor: pop and compare expected data whenever a ready pulse shows up.
         begin
            logic [63:0] e64;
            logic [31:0] e32;
            while (!all_done) begin
               @(negedge clock);
               if (d_ready | if_ready) chk("ready exclusive", {63'd0, d_ready & if_ready}, 64'd0);
               if (d_ready) begin
                  if (d_exp.size() == 0) chk("unexpected d_ready", {63'd0, d_ready}, 64'd0);
                  else begin
                     e64 = d_exp.pop_front();
                     chk("d_rdata", d_rdata, e64);
                  end
               end
               if (if_ready) begin
                  if (f_exp.size() == 0) chk("unexpected if_ready", {63'd0, if_ready}, 64'd0);
                  else begin
                     e32 = f_exp.pop_front();
                     chk("if_rdata", {32'd0, if_rdata}, {32'd0, e32});
                  end
               end
            end
         end
         // Stimulus: directed scenarios, then randomized traffic.
         begin
            int ng;
            logic prev;
            logic [3:0] pat;
            #2 reset = 1'b1;
            repeat (2) tick();
            chk("reset m_req", {63'd0, m_req}, 64'd0);
            chk("reset m_we", {63'd0, m_we}, 64'd0);
            chk("reset m_addr", m_addr, 64'd0);
            chk("reset m_wdata", m_wdata, 64'd0);
            chk("reset readies", {62'd0, if_ready, d_ready}, 64'd0);
            chk("reset rdata", d_rdata | {32'd0, if_rdata}, 64'd0);
            reset = 1'b0;
            tick();

            // Load with two-cycle memory latency.
            d_read = 1'b1; d_addr = 64'h40;
            d_exp.push_back(64'hDEADBEEF_CAFEF00D);
            last_rd = 64'hDEADBEEF_CAFEF00D;
            tick();
            chk("load m_req", {63'd0, m_req}, 64'd1);
            chk("load m_we", {63'd0, m_we}, 64'd0);
            chk("load m_addr", m_addr, 64'h40);
            chk("load stall_mem", {63'd0, stall_mem}, 64'd1);
            tick();
            m_ack = 1'b1; m_rdata = 64'hDEADBEEF_CAFEF00D;
            tick();
            m_ack = 1'b0;
            chk("load stall_mem at ready", {63'd0, stall_mem}, 64'd0);
            d_read = 1'b0;
            chk("load m_req released", {63'd0, m_req}, 64'd0);
            tick();

            // Fetch word select, upper then lower word.
            for (int i = 0; i < 2; i++) begin
               if_addr = (i == 0) ? 64'h104 : 64'h100;
               f_exp.push_back((i == 0) ? 32'h11111111 : 32'h22222222);
               if_req = 1'b1;
               tick();
               chk("fetch m_addr", m_addr, if_addr);
               chk("fetch stall_if", {63'd0, stall_if}, 64'd1);
               m_ack = 1'b1; m_rdata = 64'h11111111_22222222;
               tick();
               m_ack = 1'b0; if_req = 1'b0;
               tick();
            end

            // Contention: three data grants then a forced fetch.
            m_ack = 1'b1; m_rdata = 64'h33333333_44444444;
            if_addr = 64'h200; if_req = 1'b1;
            d_write = 1'b1; d_addr = 64'h80; d_wdata = 64'h77;
            repeat (3) d_exp.push_back(last_rd);
            f_exp.push_back(32'h44444444);
            ng = 0; prev = 1'b0; pat = 4'b0111;
            for (int c = 0; c < 8; c++) begin
               tick();
               if (m_req && !prev) begin
                  if (ng < 4) chk($sformatf("contention grant %0d m_we", ng), {63'd0, m_we}, {63'd0, pat[ng]});
                  ng++;
               end
               prev = m_req;
            end
            m_ack = 1'b0; if_req = 1'b0; d_write = 1'b0;
            chk("contention grant count", 64'(ng), 64'd4);
            chk("contention starve_cnt", 64'(dut.starve_q), 64'd0);
            repeat (2) tick();

            // Flush while fetch is outstanding.
            if_addr = 64'h300; if_req = 1'b1;
            tick();
            tick();
            flush = 1'b1;
            tick();
            flush = 1'b0; if_req = 1'b0;
            chk("flush drop m_req", {63'd0, m_req}, 64'd1);
            tick();
            chk("flush drop m_req held", {63'd0, m_req}, 64'd1);
            m_ack = 1'b1; m_rdata = 64'h55555555_66666666;
            tick();
            m_ack = 1'b0;
            chk("flush drop done", {63'd0, m_req}, 64'd0);
            repeat (2) tick();

            // Reset in the middle of a data access.
            d_read = 1'b1; d_addr = 64'h48;
            tick();
            chk("rst-mid m_req before", {63'd0, m_req}, 64'd1);
            #2 reset = 1'b1;
            #1;
            chk("rst-mid m_req async", {63'd0, m_req}, 64'd0);
            d_read = 1'b0;
            last_rd = 64'd0;
            tick();
            reset = 1'b0;
            m_ack = 1'b1; m_rdata = 64'h99999999_99999999;
            repeat (2) tick();
            m_ack = 1'b0;
            chk("rst-mid ack ignored", {63'd0, m_req}, 64'd0);
            chk("rst-mid d_rdata", d_rdata, 64'd0);
            tick();

            // Read and write together behaves as a store.
            d_read = 1'b1; d_write = 1'b1; d_addr = 64'h50; d_wdata = 64'hA5;
            d_exp.push_back(last_rd);
            tick();
            chk("rw m_we", {63'd0, m_we}, 64'd1);
            chk("rw m_wdata", m_wdata, 64'hA5);
            chk("rw m_addr", m_addr, 64'h50);
            m_ack = 1'b1; m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
            tick();
            m_ack = 1'b0; d_read = 1'b0; d_write = 1'b0;
            repeat (3) tick();

            // Randomized traffic against the memory model.
            fork
               begin
                  int op, cnt;
                  logic [63:0] a, w;
                  for (int n = 0; n < 60; n++) begin
                     repeat ($urandom_range(0, 3)) tick();
                     op = $urandom_range(0, 2);
                     a = {53'd0, 5'($urandom_range(0, 31)), 6'd0} >> 3;
                     a = {a[60:0], 3'b000};
                     w = {$urandom, $urandom};
                     if (op == 0) begin
                        last_rd = ref_get(a);
                        d_exp.push_back(last_rd);
                     end else begin
                        ref_mem[a] = w;
                        d_exp.push_back(last_rd);
                     end
                     d_addr = a; d_wdata = w;
                     d_read = (op != 1); d_write = (op != 0);
                     cnt = 0;
                     do begin
                        tick();
                        cnt++;
                     end while (!d_ready && cnt < 400);
                     if (!d_ready) chk("data timeout", {63'd0, d_ready}, 64'd1);
                     d_read = 1'b0; d_write = 1'b0;
                  end
                  d_done = 1'b1;
               end
               begin
                  int cnt;
                  logic [63:0] a, wd;
                  for (int n = 0; n < 40; n++) begin
                     repeat ($urandom_range(0, 4)) tick();
                     a = 64'h1000 + 64'($urandom_range(0, 63)) * 64'd4;
                     wd = ref_get({a[63:3], 3'b000});
                     f_exp.push_back(a[2] ? wd[63:32] : wd[31:0]);
                     if_addr = a; if_req = 1'b1;
                     cnt = 0;
                     do begin
                        tick();
                        cnt++;
                     end while (!if_ready && cnt < 400);
                     if (!if_ready) chk("fetch timeout", {63'd0, if_ready}, 64'd1);
                     if_req = 1'b0;
                  end
                  f_done = 1'b1;
               end
               begin
                  int wc;
                  logic [63:0] k;
                  wc = $urandom_range(0, 3);
                  while (!(d_done && f_done)) begin
                     @(negedge clock);
                     if (m_ack) m_ack = 1'b0;
                     else if (m_req) begin
                        if (wc == 0) begin
                           k = {m_addr[63:3], 3'b000};
                           m_rdata = mem_get(k);
                           if (m_we) mem[k] = m_wdata;
                           m_ack = 1'b1;
                           wc = $urandom_range(0, 3);
                        end else wc--;
                     end
                  end
                  m_ack = 1'b0;
               end
               begin
                  while (!(d_done && f_done)) begin
                     tick();
                     flush = ($urandom_range(0, 9) == 0);
                  end
                  flush = 1'b0;
               end
            join
            repeat (5) tick();
            chk("data queue drained", 64'(d_exp.size()), 64'd0);
            chk("fetch queue drained", 64'(f_exp.size()), 64'd0);
            all_done = 1'b1;
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
